axi_port_arbiter: RTL and testbench

- Shares the single DDR AXI port (combined address channel with ATYPE, plus W/R/B channels) between NUM_REQ=2 requesters, e.g. the UART write path and the read-back/compare path.
- Grants are round-robin, with exactly one transaction outstanding at a time.
- Latches the winner's command, drives the DDR address channel, and routes W/R/B traffic to and from the granted requester.
- Generates WLAST itself from a beat counter and flags any protocol mismatch by the requester.

---
 rtl/axi_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/axi_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_axi_port_arbiter.sv | 558 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the DDR port arbiter.
// State encoding plus fixed AXI field values.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } arb_state_t;

    localparam logic [2:0] ASIZE_32B  = 3'b101;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker.
// Combinational grant, registered last-grant pointer.
module rr_arbiter2 (
    input  logic       axi_clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last;

    // Favour the requester not served last when both ask.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        unique case (req)
            2'b11:   gnt_idx = ~last;
            2'b10:   gnt_idx = 1'b1;
            default: gnt_idx = 1'b0;
        endcase
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn)
            last <= 1'b1;
        else if (upd)
            last <= upd_idx;
    end

endmodule

// File: rtl/axi_port_arbiter.sv
// axi_port_arbiter: shares one DDR AXI port between two requesters.
// Define ARB_TIMEOUT_EN to add the transaction watchdog (o_timeout).
module axi_port_arbiter
    import axi_arb_pkg::*;
#(
    parameter int         NUM_REQ        = 2,
    parameter logic [7:0] AID_BASE       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic               axi_clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] i_cmd_valid,
    output logic [NUM_REQ-1:0] o_cmd_ready,
    input  logic [63:0]        i_cmd_addr,
    input  logic [15:0]        i_cmd_len,
    input  logic [NUM_REQ-1:0] i_cmd_type,
    input  logic [511:0]       i_wdata,
    input  logic [NUM_REQ-1:0] i_wvalid,
    input  logic [NUM_REQ-1:0] i_wlast,
    output logic [NUM_REQ-1:0] o_wready,
    output logic [255:0]       o_rdata,
    output logic [NUM_REQ-1:0] o_rvalid,
    output logic               o_rlast,
    input  logic [NUM_REQ-1:0] i_rready,
    output logic [NUM_REQ-1:0] o_done,
    output logic               o_resp_err,
    output logic               o_proto_err,
    output logic               o_busy,
    output logic               o_grant,
    output logic               o_timeout,
    output logic [7:0]         DDR_AID_0,
    output logic [31:0]        DDR_AADDR_0,
    output logic [7:0]         DDR_ALEN_0,
    output logic [2:0]         DDR_ASIZE_0,
    output logic [1:0]         DDR_ABURST_0,
    output logic [1:0]         DDR_ALOCK_0,
    output logic               DDR_AVALID_0,
    output logic               DDR_ATYPE_0,
    input  logic               DDR_AREADY_0,
    output logic [7:0]         DDR_WID_0,
    output logic [255:0]       DDR_WDATA_0,
    output logic [31:0]        DDR_WSTRB_0,
    output logic               DDR_WLAST_0,
    output logic               DDR_WVALID_0,
    input  logic               DDR_WREADY_0,
    input  logic [255:0]       DDR_RDATA_0,
    input  logic               DDR_RLAST_0,
    input  logic               DDR_RVALID_0,
    input  logic [1:0]         DDR_RRESP_0,
    output logic               DDR_RREADY_0,
    input  logic               DDR_BVALID_0,
    input  logic [1:0]         DDR_BRESP_0,
    output logic               DDR_BREADY_0
);

    arb_state_t state;
    logic       g;
    logic [1:0] sel;
    logic [7:0] cnt;
    logic       rerr;
    logic       pick_vld;
    logic       pick_idx;
    logic       hs_a;
    logic       hs_w;
    logic       hs_b;
    logic       hs_r;
    logic       r_bad;
    logic       tmo;
    logic       fin;

    assign sel    = g ? 2'b10 : 2'b01;
    assign o_busy  = (state != ST_IDLE);
    assign o_grant = g;

    assign DDR_ASIZE_0  = ASIZE_32B;
    assign DDR_ABURST_0 = BURST_INCR;
    assign DDR_ALOCK_0  = 2'b00;
    assign DDR_WSTRB_0  = 32'hFFFF_FFFF;
    assign DDR_WID_0    = DDR_AID_0;

    assign DDR_WVALID_0 = (state == ST_WDATA) & i_wvalid[g];
    assign DDR_WDATA_0  = (state != ST_WDATA) ? '0 :
                          g ? i_wdata[511:256] : i_wdata[255:0];
    assign DDR_WLAST_0  = (state == ST_WDATA) & (cnt == 8'd0);
    assign o_wready     = (state == ST_WDATA && DDR_WREADY_0) ?
                          sel : 2'b00;

    assign DDR_BREADY_0 = (state == ST_WRESP);

    assign DDR_RREADY_0 = (state == ST_RDATA) & i_rready[g];
    assign o_rvalid     = (state == ST_RDATA && DDR_RVALID_0) ?
                          sel : 2'b00;
    assign o_rdata      = DDR_RDATA_0;
    assign o_rlast      = (state == ST_RDATA) & DDR_RLAST_0;

    assign hs_a  = DDR_AVALID_0 & DDR_AREADY_0;
    assign hs_w  = DDR_WVALID_0 & DDR_WREADY_0;
    assign hs_b  = DDR_BVALID_0 & DDR_BREADY_0;
    assign hs_r  = DDR_RVALID_0 & DDR_RREADY_0;
    assign r_bad = (DDR_RRESP_0 != RESP_OKAY);
    assign fin   = hs_b | (hs_r & DDR_RLAST_0) | tmo;

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] WD_MAX = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd;
    logic        any_hs;

    assign any_hs = hs_a | hs_w | hs_b | hs_r;
    assign tmo    = (state != ST_IDLE) & ~any_hs & (wd == WD_MAX);

    // Watchdog: cycles since the last handshake of a live transaction.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn)
            wd <= '0;
        else if (state == ST_IDLE || any_hs)
            wd <= '0;
        else
            wd <= wd + 32'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    rr_arbiter2 u_rr (
        .axi_clk (axi_clk),
        .rstn    (rstn),
        .req     (i_cmd_valid),
        .upd     (fin),
        .upd_idx (g),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    // Transaction FSM with registered command, status and pulse outputs.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            g            <= 1'b0;
            cnt          <= '0;
            rerr         <= 1'b0;
            DDR_AID_0    <= '0;
            DDR_AADDR_0  <= '0;
            DDR_ALEN_0   <= '0;
            DDR_AVALID_0 <= 1'b0;
            DDR_ATYPE_0  <= 1'b0;
            o_cmd_ready  <= '0;
            o_done       <= '0;
            o_resp_err   <= 1'b0;
            o_proto_err  <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_cmd_ready <= '0;
            o_done      <= '0;
            o_resp_err  <= 1'b0;
            o_timeout   <= o_timeout | tmo;
            if (tmo) begin
                state        <= ST_IDLE;
                DDR_AVALID_0 <= 1'b0;
                o_done       <= sel;
                o_resp_err   <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (pick_vld) begin
                            g            <= pick_idx;
                            o_cmd_ready  <= pick_idx ? 2'b10 : 2'b01;
                            DDR_AID_0    <= AID_BASE + {7'd0, pick_idx};
                            DDR_AADDR_0  <= pick_idx ? i_cmd_addr[63:32]
                                                     : i_cmd_addr[31:0];
                            DDR_ALEN_0   <= pick_idx ? i_cmd_len[15:8]
                                                     : i_cmd_len[7:0];
                            DDR_ATYPE_0  <= i_cmd_type[pick_idx];
                            DDR_AVALID_0 <= 1'b1;
                            state        <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (hs_a) begin
                            DDR_AVALID_0 <= 1'b0;
                            cnt          <= DDR_ALEN_0;
                            rerr         <= 1'b0;
                            state        <= DDR_ATYPE_0 ? ST_WDATA
                                                        : ST_RDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (hs_w) begin
                            cnt <= cnt - 8'd1;
                            if (i_wlast[g] != DDR_WLAST_0)
                                o_proto_err <= 1'b1;
                            if (DDR_WLAST_0)
                                state <= ST_WRESP;
                        end
                    end
                    ST_WRESP: begin
                        if (hs_b) begin
                            o_done     <= sel;
                            o_resp_err <= (DDR_BRESP_0 != RESP_OKAY);
                            state      <= ST_IDLE;
                        end
                    end
                    ST_RDATA: begin
                        if (hs_r) begin
                            rerr <= rerr | r_bad;
                            if (DDR_RLAST_0) begin
                                o_done     <= sel;
                                o_resp_err <= rerr | r_bad;
                                state      <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_port_arbiter.sv
// tb_axi_port_arbiter: randomized self-checking bench for the DDR arbiter.
// The bench plays both requesters and the DDR slave.
module tb_axi_port_arbiter;

    logic         axi_clk;
    logic         rstn;
    logic [1:0]   i_cmd_valid;
    logic [1:0]   o_cmd_ready;
    logic [63:0]  i_cmd_addr;
    logic [15:0]  i_cmd_len;
    logic [1:0]   i_cmd_type;
    logic [511:0] i_wdata;
    logic [1:0]   i_wvalid;
    logic [1:0]   i_wlast;
    logic [1:0]   o_wready;
    logic [255:0] o_rdata;
    logic [1:0]   o_rvalid;
    logic         o_rlast;
    logic [1:0]   i_rready;
    logic [1:0]   o_done;
    logic         o_resp_err;
    logic         o_proto_err;
    logic         o_busy;
    logic         o_grant;
    logic         o_timeout;
    logic [7:0]   DDR_AID_0;
    logic [31:0]  DDR_AADDR_0;
    logic [7:0]   DDR_ALEN_0;
    logic [2:0]   DDR_ASIZE_0;
    logic [1:0]   DDR_ABURST_0;
    logic [1:0]   DDR_ALOCK_0;
    logic         DDR_AVALID_0;
    logic         DDR_ATYPE_0;
    logic         DDR_AREADY_0;
    logic [7:0]   DDR_WID_0;
    logic [255:0] DDR_WDATA_0;
    logic [31:0]  DDR_WSTRB_0;
    logic         DDR_WLAST_0;
    logic         DDR_WVALID_0;
    logic         DDR_WREADY_0;
    logic [255:0] DDR_RDATA_0;
    logic         DDR_RLAST_0;
    logic         DDR_RVALID_0;
    logic [1:0]   DDR_RRESP_0;
    logic         DDR_RREADY_0;
    logic         DDR_BVALID_0;
    logic [1:0]   DDR_BRESP_0;
    logic         DDR_BREADY_0;

    int nvec;
    int nerr;
    int m_last;

    axi_port_arbiter #(
        .NUM_REQ        (2),
        .AID_BASE       (8'h00),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .axi_clk      (axi_clk),
        .rstn         (rstn),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_len    (i_cmd_len),
        .i_cmd_type   (i_cmd_type),
        .i_wdata      (i_wdata),
        .i_wvalid     (i_wvalid),
        .i_wlast      (i_wlast),
        .o_wready     (o_wready),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_rlast      (o_rlast),
        .i_rready     (i_rready),
        .o_done       (o_done),
        .o_resp_err   (o_resp_err),
        .o_proto_err  (o_proto_err),
        .o_busy       (o_busy),
        .o_grant      (o_grant),
        .o_timeout    (o_timeout),
        .DDR_AID_0    (DDR_AID_0),
        .DDR_AADDR_0  (DDR_AADDR_0),
        .DDR_ALEN_0   (DDR_ALEN_0),
        .DDR_ASIZE_0  (DDR_ASIZE_0),
        .DDR_ABURST_0 (DDR_ABURST_0),
        .DDR_ALOCK_0  (DDR_ALOCK_0),
        .DDR_AVALID_0 (DDR_AVALID_0),
        .DDR_ATYPE_0  (DDR_ATYPE_0),
        .DDR_AREADY_0 (DDR_AREADY_0),
        .DDR_WID_0    (DDR_WID_0),
        .DDR_WDATA_0  (DDR_WDATA_0),
        .DDR_WSTRB_0  (DDR_WSTRB_0),
        .DDR_WLAST_0  (DDR_WLAST_0),
        .DDR_WVALID_0 (DDR_WVALID_0),
        .DDR_WREADY_0 (DDR_WREADY_0),
        .DDR_RDATA_0  (DDR_RDATA_0),
        .DDR_RLAST_0  (DDR_RLAST_0),
        .DDR_RVALID_0 (DDR_RVALID_0),
        .DDR_RRESP_0  (DDR_RRESP_0),
        .DDR_RREADY_0 (DDR_RREADY_0),
        .DDR_BVALID_0 (DDR_BVALID_0),
        .DDR_BRESP_0  (DDR_BRESP_0),
        .DDR_BREADY_0 (DDR_BREADY_0)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Round-robin rule: a tie goes to the one not served last.
    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b11)
            return 1 - m_last;
        return v[1] ? 1 : 0;
    endfunction

    // Outputs that must read zero while in reset.
    function automatic logic [333:0] zero_outs();
        return {o_cmd_ready, o_wready, o_rvalid, o_rlast, o_done,
                o_resp_err, o_proto_err, o_busy, o_grant, o_timeout,
                DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ALOCK_0,
                DDR_AVALID_0, DDR_ATYPE_0,
                DDR_WID_0, DDR_WDATA_0, DDR_WLAST_0, DDR_WVALID_0,
                DDR_RREADY_0, DDR_BREADY_0};
    endfunction

    task automatic clear_inputs();
        i_cmd_valid  = '0;
        i_cmd_addr   = '0;
        i_cmd_len    = '0;
        i_cmd_type   = '0;
        i_wdata      = '0;
        i_wvalid     = '0;
        i_wlast      = '0;
        i_rready     = '0;
        DDR_AREADY_0 = 1'b0;
        DDR_WREADY_0 = 1'b0;
        DDR_RDATA_0  = '0;
        DDR_RLAST_0  = 1'b0;
        DDR_RVALID_0 = 1'b0;
        DDR_RRESP_0  = '0;
        DDR_BVALID_0 = 1'b0;
        DDR_BRESP_0  = '0;
    endtask

    // Drives one full transaction and reports what the DUT did.
    task automatic run_txn(
        input  logic [1:0]  vmask,
        input  logic [63:0] addr64,
        input  int          len,
        input  bit          wr,
        input  int          dly,
        input  int          err_beat,
        input  int          bad_beat,
        input  bit          no_b,
        output int          gnt,
        output logic [31:0] a_addr,
        output logic [7:0]  a_len,
        output logic [7:0]  a_id,
        output logic        a_type,
        output logic        av,
        output int          beats,
        output int          lastb,
        output logic [1:0]  done_v,
        output logic        rerr,
        output int          derr,
        output int          bwait
    );
        logic [255:0] d;
        logic [1:0]   sel;
        logic [7:0]   l8;
        bit           lw;
        gnt = -1; a_addr = '0; a_len = '0; a_id = '0; a_type = 1'b0;
        av = 1'b0; beats = 0; lastb = -1; done_v = '0; rerr = 1'b0;
        derr = 0; bwait = -1;
        l8 = len[7:0];
        i_cmd_addr  = addr64;
        i_cmd_len   = {l8, l8};
        i_cmd_type  = wr ? 2'b11 : 2'b00;
        i_cmd_valid = vmask;
        for (int i = 0; i < 20; i++) begin
            @(negedge axi_clk);
            if (o_cmd_ready != 2'b00) begin
                gnt    = o_cmd_ready[1] ? 1 : 0;
                a_addr = DDR_AADDR_0;
                a_len  = DDR_ALEN_0;
                a_id   = DDR_AID_0;
                a_type = DDR_ATYPE_0;
                av     = DDR_AVALID_0;
                break;
            end
        end
        i_cmd_valid = '0;
        if (gnt < 0)
            return;
        sel = (gnt != 0) ? 2'b10 : 2'b01;
        repeat (dly) @(negedge axi_clk);
        DDR_AREADY_0 = 1'b1;
        @(negedge axi_clk);
        DDR_AREADY_0 = 1'b0;
        if (wr) begin
            DDR_WREADY_0 = 1'b1;
            for (int i = 0; i < 40 && beats <= len; i++) begin
                for (int k = 0; k < 8; k++)
                    d[k*32 +: 32] = $urandom;
                i_wdata  = (gnt != 0) ? {d, 256'h0} : {256'h0, d};
                i_wvalid = sel;
                lw = (beats == len) ^ (beats == bad_beat);
                i_wlast  = lw ? sel : 2'b00;
                #1;
                if (DDR_WVALID_0 && DDR_WREADY_0) begin
                    if (DDR_WDATA_0 !== d) derr++;
                    if (o_wready !== sel) derr++;
                    if (DDR_WID_0 !== a_id) derr++;
                    if (DDR_WLAST_0 && lastb < 0) lastb = beats;
                    beats++;
                end
                @(negedge axi_clk);
            end
            i_wvalid = '0;
            i_wlast  = '0;
            DDR_WREADY_0 = 1'b0;
            for (int i = 0; i < 40; i++) begin
                DDR_BVALID_0 = !no_b;
                DDR_BRESP_0  = (err_beat >= 0) ? 2'b10 : 2'b00;
                @(negedge axi_clk);
                if (o_done != 2'b00) begin
                    done_v = o_done;
                    rerr   = o_resp_err;
                    bwait  = i + 1;
                    break;
                end
            end
            DDR_BVALID_0 = 1'b0;
            DDR_BRESP_0  = '0;
        end else begin
            for (int i = 0; i < 120 && beats <= len; i++) begin
                for (int k = 0; k < 8; k++)
                    d[k*32 +: 32] = $urandom;
                i_rready     = ($urandom_range(0, 1) != 0) ? sel : 2'b00;
                DDR_RVALID_0 = 1'b1;
                DDR_RDATA_0  = d;
                DDR_RLAST_0  = (beats == len);
                DDR_RRESP_0  = (beats == err_beat) ? 2'b10 : 2'b00;
                #1;
                if (o_rvalid !== sel) derr++;
                if (DDR_RREADY_0 !== i_rready[gnt]) derr++;
                if (o_rdata !== d) derr++;
                if (o_rlast !== (beats == len)) derr++;
                if (DDR_RREADY_0) begin
                    if (o_rlast && lastb < 0) lastb = beats;
                    beats++;
                end
                @(negedge axi_clk);
            end
            DDR_RVALID_0 = 1'b0;
            DDR_RLAST_0  = 1'b0;
            DDR_RRESP_0  = '0;
            i_rready     = '0;
            done_v = o_done;
            rerr   = o_resp_err;
        end
    endtask

    task automatic test_reset();
        logic [333:0] z;
        logic [36:0]  c;
        rstn = 1'b0;
        clear_inputs();
        repeat (3) @(negedge axi_clk);
        z = zero_outs();
        c = {DDR_WSTRB_0, DDR_ASIZE_0, DDR_ABURST_0};
        nvec++;
        if (z !== '0) begin
            nerr++;
            $display("FAIL reset_zero: got %h want 0", z);
        end
        nvec++;
        if (c !== {32'hFFFF_FFFF, 3'b101, 2'b01}) begin
            nerr++;
            $display("FAIL reset_const: got %h want ffffffff/5/1", c);
        end
        rstn = 1'b1;
        m_last = 1;
        @(negedge axi_clk);
    endtask

    task automatic test_write();
        int gnt, beats, lastb, derr, bwait;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        run_txn(2'b01, 64'h0000_0000_0000_0100, 3, 1'b1, 2, -1, -1,
                1'b0, gnt, aa, al, aid, at, av, beats, lastb, dn, rerr,
                derr, bwait);
        nvec++;
        if (gnt !== 0 || aa !== 32'h100 || al !== 8'd3 ||
            aid !== 8'h00 || at !== 1'b1 || av !== 1'b1) begin
            nerr++;
            $display("FAIL write_cmd: got g%0d a%h l%0d id%0d t%0d v%0d want g0 a100 l3 id0 t1 v1",
                     gnt, aa, al, aid, at, av);
        end
        nvec++;
        if (beats !== 4 || lastb !== 3 || derr !== 0) begin
            nerr++;
            $display("FAIL write_beats: got n%0d last%0d derr%0d want n4 last3 derr0",
                     beats, lastb, derr);
        end
        nvec++;
        if (dn !== 2'b01 || rerr !== 1'b0 || bwait !== 1) begin
            nerr++;
            $display("FAIL write_done: got d%b e%0d w%0d want d01 e0 w1",
                     dn, rerr, bwait);
        end
        m_last = 0;
    endtask

    task automatic test_round_robin();
        int gnt, beats, lastb, derr, bwait, eg;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        for (int t = 0; t < 3; t++) begin
            eg = exp_grant(2'b11);
            run_txn(2'b11, {$urandom, $urandom}, 0, 1'b1, 0, -1, -1,
                    1'b0, gnt, aa, al, aid, at, av, beats, lastb, dn,
                    rerr, derr, bwait);
            nvec++;
            if (gnt !== eg || o_grant !== 1'(eg) || aid !== 8'(eg)) begin
                nerr++;
                $display("FAIL rr_grant%0d: got %0d (o_grant %0d) want %0d",
                         t, gnt, o_grant, eg);
            end
            m_last = eg;
            @(negedge axi_clk);
        end
    endtask

    task automatic test_read();
        int gnt, beats, lastb, derr, bwait;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        logic [63:0] a64;
        a64 = {$urandom, $urandom};
        run_txn(2'b10, a64, 7, 1'b0, 1, 4, -1, 1'b0, gnt, aa, al, aid,
                at, av, beats, lastb, dn, rerr, derr, bwait);
        nvec++;
        if (gnt !== 1 || aa !== a64[63:32] || at !== 1'b0) begin
            nerr++;
            $display("FAIL read_cmd: got g%0d a%h t%0d want g1 a%h t0",
                     gnt, aa, at, a64[63:32]);
        end
        nvec++;
        if (beats !== 8 || lastb !== 7 || derr !== 0) begin
            nerr++;
            $display("FAIL read_beats: got n%0d last%0d derr%0d want n8 last7 derr0",
                     beats, lastb, derr);
        end
        nvec++;
        if (dn !== 2'b10 || rerr !== 1'b1) begin
            nerr++;
            $display("FAIL read_done: got d%b e%0d want d10 e1", dn, rerr);
        end
        m_last = 1;
    endtask

    task automatic test_random();
        int gnt, beats, lastb, derr, bwait, eg, len, eb;
        logic [31:0] aa, ea;
        logic [7:0] al, aid;
        logic at, av, rerr, wr;
        logic [1:0] dn, vm;
        logic [63:0] a64;
        for (int t = 0; t < 8; t++) begin
            vm  = 2'($urandom_range(1, 3));
            wr  = 1'($urandom_range(0, 1));
            len = (t == 0) ? 0 : int'($urandom_range(0, 5));
            a64 = {$urandom, $urandom};
            if (wr)
                eb = ($urandom_range(0, 2) == 0) ? 0 : -1;
            else
                eb = ($urandom_range(0, 2) == 0) ?
                     int'($urandom_range(0, len)) : -1;
            eg = exp_grant(vm);
            ea = (eg != 0) ? a64[63:32] : a64[31:0];
            run_txn(vm, a64, len, wr, int'($urandom_range(0, 3)), eb, -1,
                    1'b0, gnt, aa, al, aid, at, av, beats, lastb, dn,
                    rerr, derr, bwait);
            nvec++;
            if (gnt !== eg || aa !== ea || al !== 8'(len) ||
                at !== wr) begin
                nerr++;
                $display("FAIL rand%0d_cmd: got g%0d a%h l%0d t%0d want g%0d a%h l%0d t%0d",
                         t, gnt, aa, al, at, eg, ea, len, wr);
            end
            nvec++;
            if (beats !== len + 1 || lastb !== len || derr !== 0) begin
                nerr++;
                $display("FAIL rand%0d_beats: got n%0d last%0d derr%0d want n%0d last%0d derr0",
                         t, beats, lastb, derr, len + 1, len);
            end
            nvec++;
            if (dn !== ((eg != 0) ? 2'b10 : 2'b01) ||
                rerr !== (eb >= 0)) begin
                nerr++;
                $display("FAIL rand%0d_done: got d%b e%0d want g%0d e%0d",
                         t, dn, rerr, eg, eb >= 0);
            end
            m_last = eg;
        end
        nvec++;
        if (o_proto_err !== 1'b0) begin
            nerr++;
            $display("FAIL rand_proto: got %0d want 0", o_proto_err);
        end
    endtask

    task automatic test_proto();
        int gnt, beats, lastb, derr, bwait;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        run_txn(2'b01, {$urandom, $urandom}, 1, 1'b1, 0, -1, 0, 1'b0,
                gnt, aa, al, aid, at, av, beats, lastb, dn, rerr, derr,
                bwait);
        nvec++;
        if (o_proto_err !== 1'b1 || beats !== 2 || lastb !== 1 ||
            dn !== 2'b01) begin
            nerr++;
            $display("FAIL proto: got p%0d n%0d last%0d d%b want p1 n2 last1 d01",
                     o_proto_err, beats, lastb, dn);
        end
        m_last = 0;
    endtask

    task automatic test_reset_mid();
        int gnt, beats, lastb, derr, bwait, seen;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        logic [333:0] z;
        seen = 0;
        i_cmd_addr  = {$urandom, $urandom};
        i_cmd_len   = {8'd3, 8'd3};
        i_cmd_type  = 2'b11;
        i_cmd_valid = 2'b10;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge axi_clk);
            if (o_cmd_ready == 2'b10) seen = 1;
        end
        i_cmd_valid  = '0;
        DDR_AREADY_0 = 1'b1;
        @(negedge axi_clk);
        DDR_AREADY_0 = 1'b0;
        DDR_WREADY_0 = 1'b1;
        i_wvalid     = 2'b10;
        i_wdata      = {$urandom, 480'h0};
        @(negedge axi_clk);
        #1;
        nvec++;
        if (seen != 1 || o_busy !== 1'b1 || DDR_WVALID_0 !== 1'b1) begin
            nerr++;
            $display("FAIL mid_setup: got seen%0d busy%0d wv%0d want 1 1 1",
                     seen, o_busy, DDR_WVALID_0);
        end
        rstn = 1'b0;
        #1;
        z = zero_outs();
        nvec++;
        if (z !== '0 || DDR_WSTRB_0 !== 32'hFFFF_FFFF ||
            DDR_ASIZE_0 !== 3'b101 || DDR_ABURST_0 !== 2'b01) begin
            nerr++;
            $display("FAIL mid_reset: got %h want 0 with fixed fields", z);
        end
        clear_inputs();
        @(negedge axi_clk);
        rstn = 1'b1;
        m_last = 1;
        @(negedge axi_clk);
        run_txn(2'b11, {$urandom, $urandom}, 0, 1'b0, 0, -1, -1, 1'b0,
                gnt, aa, al, aid, at, av, beats, lastb, dn, rerr, derr,
                bwait);
        nvec++;
        if (gnt !== 0 || dn !== 2'b01 || beats !== 1) begin
            nerr++;
            $display("FAIL mid_after: got g%0d d%b n%0d want g0 d01 n1",
                     gnt, dn, beats);
        end
        m_last = 0;
    endtask

    task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
        int gnt, beats, lastb, derr, bwait;
        logic [31:0] aa;
        logic [7:0] al, aid;
        logic at, av, rerr;
        logic [1:0] dn;
        nvec++;
        if (o_timeout !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_pre: got %0d want 0", o_timeout);
        end
        run_txn(2'b11, {$urandom, $urandom}, 0, 1'b1, 0, -1, -1, 1'b1,
                gnt, aa, al, aid, at, av, beats, lastb, dn, rerr, derr,
                bwait);
        nvec++;
        if (gnt !== 1 || dn !== 2'b10 || rerr !== 1'b1 ||
            bwait !== 16) begin
            nerr++;
            $display("FAIL tmo_done: got g%0d d%b e%0d w%0d want g1 d10 e1 w16",
                     gnt, dn, rerr, bwait);
        end
        nvec++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0 ||
            DDR_BREADY_0 !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_state: got t%0d b%0d br%0d want t1 b0 br0",
                     o_timeout, o_busy, DDR_BREADY_0);
        end
`else
        repeat (2) @(negedge axi_clk);
        nvec++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_off: got t%0d b%0d want t0 b0",
                     o_timeout, o_busy);
        end
`endif
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        m_last = 1;
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_random();
        test_proto();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
